// File: rtl/rr_arb_bin_if.sv
// rr_arb_bin_if: request bundle from WIDTH requesters plus the single output
// channel towards the consumer, shared by the arbiter and its environment.
interface rr_arb_bin_if #(
    parameter type DAT_T = logic [4-1:0],
    parameter int  WIDTH = 4
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic [WIDTH-1:0]     req_vld;
    logic [WIDTH-1:0]     req_rdy;
    DAT_T                 req_dat [WIDTH];
    logic                 out_vld;
    logic                 out_rdy;
    DAT_T                 out_dat;
    logic [WIDTH_LOG-1:0] out_bin;

    modport master (
        output req_vld, req_dat, out_rdy,
        input  req_rdy, out_vld, out_dat, out_bin
    );

    modport slave (
        input  req_vld, req_dat, out_rdy,
        output req_rdy, out_vld, out_dat, out_bin
    );
endinterface

// File: rtl/rr_arb_bin.sv
// rr_arb_bin: round-robin arbiter with a one-deep registered output stage
// that reports the winning requester as a binary index next to its data.
module rr_arb_bin #(
    parameter type DAT_T = logic [4-1:0],
    parameter int  WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_bin_if.slave  bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $fatal(1, "rr_arb_bin: WIDTH must be at least 2");
        end
    endgenerate

    logic [WIDTH_LOG-1:0] r_ptr;
    logic [WIDTH_LOG-1:0] r_out_bin;
    logic                 r_out_vld;
    DAT_T                 r_out_dat;
    logic [WIDTH_LOG-1:0] w_sel;
    logic                 w_load;

    // Modular add that stays below WIDTH even when WIDTH is not a power of 2.
    function automatic logic [WIDTH_LOG-1:0] wrap_add(input logic [WIDTH_LOG-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return WIDTH_LOG'(s >= WIDTH ? s - WIDTH : s);
    endfunction

    // Scan from the far end back to ptr so the nearest valid requester wins.
    always_comb begin
        w_sel = r_ptr;
        for (int k = WIDTH - 1; k >= 0; k--)
            if (bus.req_vld[wrap_add(r_ptr, k)]) w_sel = wrap_add(r_ptr, k);
    end

    assign w_load      = rst_n && |bus.req_vld && (!r_out_vld || bus.out_rdy);
    assign bus.req_rdy = w_load ? WIDTH'(1) << w_sel : '0;
    assign bus.out_vld = r_out_vld;
    assign bus.out_dat = r_out_dat;
    assign bus.out_bin = r_out_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_bin <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            r_out_vld <= 1'b1;
            r_out_dat <= bus.req_dat[w_sel];
            r_out_bin <= w_sel;
            r_ptr     <= (w_sel == WIDTH_LOG'(WIDTH - 1)) ? '0 : w_sel + WIDTH_LOG'(1);
        end else if (bus.out_rdy) begin
            r_out_vld <= 1'b0;
        end
    end
endmodule

// File: doc/rr_arb_bin.md
RR_ARB_BIN -- requirements
Module: rr_arb_bin

Interface
REQ-001 Parameter DAT_T, default logic [4-1:0], SHALL be the data type carried per requester.
REQ-002 Parameter WIDTH, default 4, SHALL be the number of requesters; legal range 2..256, any value, not only powers of 2.
REQ-003 Localparam WIDTH_LOG = $clog2(WIDTH) SHALL be the binary grant index width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_vld  input  [WIDTH-1:0]  SHALL be per-requester valid.
REQ-007 req_dat  input  DAT_T [WIDTH-1:0] (unpacked array)  SHALL be per-requester data.
REQ-008 req_rdy  output  [WIDTH-1:0]  SHALL be per-requester ready, one-hot or zero.
REQ-009 out_vld  output  1  SHALL be output valid.
REQ-010 out_dat  output  DAT_T  SHALL be output data.
REQ-011 out_bin  output  [WIDTH_LOG-1:0]  SHALL be the binary index of the requester whose data is in out_dat.
REQ-012 out_rdy  input  1  SHALL be output ready from the consumer.

Function
REQ-013 A transfer on a port SHALL occur in a cycle where its vld and rdy are both high.
REQ-014 Internal pointer ptr [WIDTH_LOG-1:0] SHALL hold the highest-priority index for the next grant.
REQ-015 Combinational sel SHALL be the first index i with req_vld[i]=1, searched circularly from ptr upward, wrapping from WIDTH-1 to 0.
REQ-016 Signal load SHALL be |req_vld && (!out_vld || out_rdy).
REQ-017 req_rdy SHALL equal one-hot(sel) when load=1, else all zero; req_rdy SHALL NOT depend on req_dat.
REQ-018 On load, out_dat <= req_dat[sel], out_bin <= sel, out_vld <= 1, and ptr <= (sel==WIDTH-1) ? 0 : sel+1.
REQ-019 When out_vld && out_rdy && !|req_vld, out_vld SHALL go to 0; out_dat, out_bin and ptr SHALL hold.
REQ-020 When out_vld && !out_rdy, out_vld, out_dat and out_bin SHALL hold, and req_rdy SHALL be zero (backpressure).
REQ-021 Latency SHALL be one cycle from a requester transfer to out_vld; with out_rdy held high, throughput SHALL be one transfer per cycle.
REQ-022 A requester that keeps req_vld high SHALL be granted again no later than WIDTH transfers after its previous grant (starvation bound).
REQ-023 A single active requester SHALL be granted every load cycle regardless of ptr.
REQ-024 ptr SHALL never take a value >= WIDTH for non-power-of-2 WIDTH.
REQ-025 Elaboration SHALL fail with $fatal if WIDTH < 2.

Reset
REQ-026 While rst_n=0: out_vld=0, out_dat='0, out_bin=0, ptr=0, req_rdy=0, independent of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the held output word, with no partial grant visible after release.
REQ-028 The first cycle after rst_n release SHALL arbitrate normally with ptr=0.

Verification (WIDTH=4, DAT_T 4 bit)
REQ-029 Reset: req_vld=4'b1111, rst_n=0 -> req_rdy=0 and out_vld=0 during reset; first grant after release is index 0.
REQ-030 Round-robin: req_vld=4'b1111 held, req_dat={3,2,1,0}, out_rdy=1 -> out_bin sequence 0,1,2,3,0 on consecutive cycles, out_dat equal to out_bin.
REQ-031 Backpressure: out_vld=1, out_bin=2, out_rdy=0 for 3 cycles -> out_dat and out_bin stable, req_rdy=0; then out_rdy=1 -> next grant is index 3 if req_vld[3]=1.
REQ-032 Wrap/skip: ptr=3, req_vld=4'b0101 -> grant 0, then grant 2, then grant 0.
REQ-033 Non-power-of-2: WIDTH=3, all requesting -> out_bin 0,1,2,0; out_bin never equals 3.
REQ-034 Async reset mid-stall: out_vld=1, out_rdy=0, rst_n pulsed low between clock edges -> out_vld drops immediately; the word is lost and never delivered.
